asym_width_fifo: RTL and testbench
==================================

Name: asym_width_fifo

Overview:
- Single-clock FIFO that converts data width between write and read ports, in either direction (narrow-to-wide or wide-to-narrow).
- Storage is an inferred RAM of narrow (minimum-width) words; each port moves RATIO narrow words per transfer on the wide side, one on the narrow side.
- Used between byte-oriented producers and word-oriented consumers (and the reverse) where the plain asymmetric RAM has no flow control.

Parameters:
- WIDTHA, 8, write data width (bits).
- WIDTHB, 32, read data width (bits).
- DEPTH, 256, capacity in narrow words; power of 2, multiple of RATIO.
- ADDRWIDTH, 8, log2(DEPTH).
- Derived: minWIDTH = min(WIDTHA,WIDTHB), maxWIDTH = max(WIDTHA,WIDTHB), RATIO = maxWIDTH/minWIDTH (power of 2, >=1), WA = WIDTHA/minWIDTH, WB = WIDTHB/minWIDTH.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of pointers/level
- we  in  1  write request
- din  in  WIDTHA  write data
- full  out  1  fewer than WA narrow slots free
- re  in  1  read request
- dout  out  WIDTHB  read data, registered
- dout_valid  out  1  dout updated this cycle
- empty  out  1  fewer than WB narrow words stored
- level  out  ADDRWIDTH+1  stored narrow words
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty

Behaviour:
- Reset (rst_n low, async): wptr=0, rptr=0, level=0, full=0, empty=1, dout=0, dout_valid=0, overflow=0, underflow=0. RAM contents not reset. Release is synchronous to clk.
- Pointers are in narrow-word units, ADDRWIDTH bits, wrap modulo DEPTH. wptr advances by WA, rptr by WB.
- Accepted write: we && !full. Narrow word i of din (bits [(i+1)*minWIDTH-1 : i*minWIDTH]) is written to RAM[wptr+i], i=0..WA-1. Lowest bits go to the lowest address.
- Accepted read: re && !empty. dout word j is taken from RAM[rptr+j], j=0..WB-1. dout and dout_valid=1 are registered one cycle after the accepted read (latency 1). dout_valid=0 in cycles without an accepted read; dout holds its last value.
- Level update: level_next = level + WA*acc_w - WB*acc_r. Simultaneous accepted read and write in one cycle is legal. Read and write address ranges are disjoint by construction, so no read-during-write hazard exists.
- Flags are combinational from the level register only: full = (level > DEPTH-WA); empty = (level < WB). Neither depends on same-cycle we/re.
- Rejected write: din dropped, no state change except overflow<=1.
- Rejected read: no dout change, dout_valid=0, underflow<=1.
- Sticky error flags clear only on reset.
- flush (sync, highest priority after reset):
  - wptr, rptr, level <= 0; dout_valid <= 0.
  - Same-cycle we/re ignored and do not set error flags.
  - dout and the error flags are retained.
- Wrap-around: address arithmetic wraps mod DEPTH. Because DEPTH is a multiple of RATIO, a wide access never straddles the wrap point.
- RATIO=1 (equal widths): degenerates to a plain synchronous FIFO; full at level=DEPTH, empty at level=0.

Test Plan:
- WIDTHA=8, WIDTHB=32, DEPTH=16: write 0x11,0x22,0x33,0x44 on consecutive cycles -> empty=1 through the 3rd write, empty=0 the cycle after the 4th; re -> next cycle dout=0x44332211, dout_valid=1, level=0, empty=1.
- Same config: write 16 bytes -> full=1 at level=16. 17th write ignored, overflow=1, level stays 16. Read 4 words -> 0x03020100..0x0F0E0D0C for data 0x00..0x0F.
- Same config at level=4: assert we (0x55) and re in the same cycle -> level=1, dout=oldest word, no error flags. Keep streaming 40 bytes in / 10 words out across pointer wrap -> data order preserved.
- WIDTHA=32, WIDTHB=8, DEPTH=16: write 0xA1B2C3D4 -> reads return 0xD4,0xC3,0xB2,0xA1. 5th read with level=0 -> underflow=1, dout unchanged, dout_valid=0.
- Reset mid-operation at level=8 with we=re=1 -> all outputs take reset values immediately. After release, a fresh write/read sequence returns only new data.
- flush at level=12 with we=1 -> level=0, empty=1, overflow unchanged, written data discarded.

Source files
------------

// File: rtl/asym_width_fifo.sv
// rtl/asym_width_fifo.sv - single-clock FIFO converting between write and read data widths
// Storage is RATIO banks of narrow words so a wide access touches one row of every bank.
module asym_width_fifo #(
    parameter int WIDTHA    = 8,
    parameter int WIDTHB    = 32,
    parameter int DEPTH     = 256,
    parameter int ADDRWIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 we,
    input  logic [WIDTHA-1:0]    din,
    output logic                 full,
    input  logic                 re,
    output logic [WIDTHB-1:0]    dout,
    output logic                 dout_valid,
    output logic                 empty,
    output logic [ADDRWIDTH:0]   level,
    output logic                 overflow,
    output logic                 underflow
);
    localparam int MINW  = (WIDTHA < WIDTHB) ? WIDTHA : WIDTHB;
    localparam int MAXW  = (WIDTHA < WIDTHB) ? WIDTHB : WIDTHA;
    localparam int RATIO = MAXW / MINW;
    localparam int WA    = WIDTHA / MINW;
    localparam int WB    = WIDTHB / MINW;
    localparam int LOGR  = $clog2(RATIO);
    localparam int BSELW = (LOGR > 0) ? LOGR : 1;
    localparam int ROWS  = DEPTH / RATIO;
    localparam int ROWW  = ADDRWIDTH - LOGR;

    localparam logic [ADDRWIDTH:0]   FULLMARK  = (ADDRWIDTH+1)'(DEPTH - WA);
    localparam logic [ADDRWIDTH:0]   EMPTYMARK = (ADDRWIDTH+1)'(WB);
    localparam logic [ADDRWIDTH:0]   WASTEP    = (ADDRWIDTH+1)'(WA);
    localparam logic [ADDRWIDTH:0]   WBSTEP    = (ADDRWIDTH+1)'(WB);
    localparam logic [ADDRWIDTH-1:0] BANKMASK  = ADDRWIDTH'(RATIO - 1);

    logic [ADDRWIDTH-1:0] wrPtr;
    logic [ADDRWIDTH-1:0] rdPtr;
    logic [ADDRWIDTH:0]   levelReg;
    logic [WIDTHB-1:0]    doutReg;
    logic [WIDTHB-1:0]    doutNext;
    logic                 doutValidReg;
    logic                 overflowReg;
    logic                 underflowReg;

    logic                 fullFlag;
    logic                 emptyFlag;
    logic                 accW;
    logic                 accR;
    logic [ROWW-1:0]      wrRow;
    logic [ROWW-1:0]      rdRow;
    logic [BSELW-1:0]     wrBank;
    logic [BSELW-1:0]     rdBank;
    logic [MINW-1:0]      rdWord [RATIO];

    // Flags look only at the stored level, never at this cycle's requests.
    assign fullFlag  = (levelReg > FULLMARK);
    assign emptyFlag = (levelReg < EMPTYMARK);
    assign accW      = we && !fullFlag && !flush;
    assign accR      = re && !emptyFlag && !flush;

    assign wrRow  = wrPtr[ADDRWIDTH-1:LOGR];
    assign rdRow  = rdPtr[ADDRWIDTH-1:LOGR];
    assign wrBank = BSELW'(wrPtr & BANKMASK);
    assign rdBank = BSELW'(rdPtr & BANKMASK);

    // The wide side is always RATIO-aligned, so it owns one full row; the narrow side picks a bank.
    for (genvar b = 0; b < RATIO; b++) begin : gBank
        localparam int WSLOT = (WA == RATIO) ? b : 0;
        logic [MINW-1:0] mem [ROWS];
        logic            bankWe;

        assign bankWe = accW && ((WA == RATIO) || (wrBank == BSELW'(b)));

        always_ff @(posedge clk) begin
            if (bankWe) begin
                mem[wrRow] <= din[WSLOT*MINW +: MINW];
            end
        end

        assign rdWord[b] = mem[rdRow];
    end

    always_comb begin
        logic [BSELW-1:0] sel;
        sel      = '0;
        doutNext = '0;
        for (int j = 0; j < WB; j++) begin
            sel = (WB == RATIO) ? BSELW'(j) : rdBank;
            doutNext[j*MINW +: MINW] = rdWord[sel];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr        <= '0;
            rdPtr        <= '0;
            levelReg     <= '0;
            doutReg      <= '0;
            doutValidReg <= 1'b0;
            overflowReg  <= 1'b0;
            underflowReg <= 1'b0;
        end else if (flush) begin
            // dout and the sticky error flags deliberately survive a flush.
            wrPtr        <= '0;
            rdPtr        <= '0;
            levelReg     <= '0;
            doutValidReg <= 1'b0;
        end else begin
            if (accW) begin
                wrPtr <= wrPtr + ADDRWIDTH'(WA);
            end
            if (accR) begin
                rdPtr   <= rdPtr + ADDRWIDTH'(WB);
                doutReg <= doutNext;
            end
            doutValidReg <= accR;
            levelReg     <= levelReg + (accW ? WASTEP : '0) - (accR ? WBSTEP : '0);
            if (we && fullFlag) begin
                overflowReg <= 1'b1;
            end
            if (re && emptyFlag) begin
                underflowReg <= 1'b1;
            end
        end
    end

    assign full       = fullFlag;
    assign empty      = emptyFlag;
    assign level      = levelReg;
    assign dout       = doutReg;
    assign dout_valid = doutValidReg;
    assign overflow   = overflowReg;
    assign underflow  = underflowReg;

endmodule

// File: tb/tb_asym_width_fifo.sv
// tb/tb_asym_width_fifo.sv - directed bench for narrow-to-wide and wide-to-narrow FIFO instances
module tb_asym_width_fifo;
    logic        clk;
    logic        rst_n;

    logic        aFlush, aWe, aRe;
    logic [7:0]  aDin;
    logic [31:0] aDout;
    logic        aDv, aFull, aEmpty, aOvf, aUnf;
    logic [4:0]  aLevel;

    logic        bFlush, bWe, bRe;
    logic [31:0] bDin;
    logic [7:0]  bDout;
    logic        bDv, bFull, bEmpty, bOvf, bUnf;
    logic [4:0]  bLevel;

    int checks = 0;
    int errors = 0;

    asym_width_fifo #(.WIDTHA(8), .WIDTHB(32), .DEPTH(16), .ADDRWIDTH(4)) uNarrowToWide (
        .clk(clk), .rst_n(rst_n), .flush(aFlush), .we(aWe), .din(aDin), .full(aFull),
        .re(aRe), .dout(aDout), .dout_valid(aDv), .empty(aEmpty), .level(aLevel),
        .overflow(aOvf), .underflow(aUnf)
    );

    asym_width_fifo #(.WIDTHA(32), .WIDTHB(8), .DEPTH(16), .ADDRWIDTH(4)) uWideToNarrow (
        .clk(clk), .rst_n(rst_n), .flush(bFlush), .we(bWe), .din(bDin), .full(bFull),
        .re(bRe), .dout(bDout), .dout_valid(bDv), .empty(bEmpty), .level(bLevel),
        .overflow(bOvf), .underflow(bUnf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic stepA(input logic w, input logic [7:0] d, input logic r);
        aWe = w; aDin = d; aRe = r;
        @(posedge clk); #1;
        aWe = 1'b0; aRe = 1'b0;
    endtask

    task automatic stepB(input logic w, input logic [31:0] d, input logic r);
        bWe = w; bDin = d; bRe = r;
        @(posedge clk); #1;
        bWe = 1'b0; bRe = 1'b0;
    endtask

    task automatic applyReset();
        aWe = 0; aRe = 0; aFlush = 0; aDin = 0;
        bWe = 0; bRe = 0; bFlush = 0; bDin = 0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++; if (aLevel !== 5'd0) begin errors++; $display("FAIL reset_level got %0d want 0", aLevel); end
        checks++; if (aFull !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", aFull); end
        checks++; if (aEmpty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", aEmpty); end
        checks++; if (aDout !== 32'h0) begin errors++; $display("FAIL reset_dout got %h want 0", aDout); end
        checks++; if (aDv !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", aDv); end
        checks++; if (aOvf !== 1'b0 || aUnf !== 1'b0) begin errors++; $display("FAIL reset_errflags got %b%b want 00", aOvf, aUnf); end
        checks++; if (bEmpty !== 1'b1 || bLevel !== 5'd0) begin errors++; $display("FAIL reset_b got empty=%b level=%0d want 1/0", bEmpty, bLevel); end
        applyReset();
    endtask

    task automatic test_basic_pack();
        logic [7:0] bytesIn [4];
        bytesIn[0] = 8'h11; bytesIn[1] = 8'h22; bytesIn[2] = 8'h33; bytesIn[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            stepA(1'b1, bytesIn[i], 1'b0);
            checks++;
            if (aEmpty !== (i < 3)) begin errors++; $display("FAIL pack_empty_%0d got %b want %b", i, aEmpty, (i < 3)); end
        end
        stepA(1'b0, 8'h00, 1'b1);
        checks++; if (aDout !== 32'h44332211) begin errors++; $display("FAIL pack_dout got %h want 44332211", aDout); end
        checks++; if (aDv !== 1'b1) begin errors++; $display("FAIL pack_valid got %b want 1", aDv); end
        checks++; if (aLevel !== 5'd0 || aEmpty !== 1'b1) begin errors++; $display("FAIL pack_after got level=%0d empty=%b want 0/1", aLevel, aEmpty); end
        stepA(1'b0, 8'h00, 1'b0);
        checks++; if (aDv !== 1'b0 || aDout !== 32'h44332211) begin errors++; $display("FAIL pack_hold got valid=%b dout=%h want 0/44332211", aDv, aDout); end
    endtask

    task automatic test_full_overflow();
        logic [31:0] expWords [4];
        expWords[0] = 32'h03020100; expWords[1] = 32'h07060504;
        expWords[2] = 32'h0B0A0908; expWords[3] = 32'h0F0E0D0C;
        for (int i = 0; i < 16; i++) begin
            stepA(1'b1, 8'(i), 1'b0);
        end
        checks++; if (aFull !== 1'b1 || aLevel !== 5'd16) begin errors++; $display("FAIL full_at16 got full=%b level=%0d want 1/16", aFull, aLevel); end
        checks++; if (aOvf !== 1'b0) begin errors++; $display("FAIL ovf_premature got %b want 0", aOvf); end
        stepA(1'b1, 8'hFF, 1'b0);
        checks++; if (aOvf !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", aOvf); end
        checks++; if (aLevel !== 5'd16) begin errors++; $display("FAIL ovf_level got %0d want 16", aLevel); end
        for (int i = 0; i < 4; i++) begin
            stepA(1'b0, 8'h00, 1'b1);
            checks++;
            if (aDout !== expWords[i] || aDv !== 1'b1) begin
                errors++; $display("FAIL full_read_%0d got %h valid=%b want %h valid=1", i, aDout, aDv, expWords[i]);
            end
        end
        checks++; if (aLevel !== 5'd0 || aFull !== 1'b0) begin errors++; $display("FAIL full_drained got level=%0d full=%b want 0/0", aLevel, aFull); end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  q [$];
        logic [31:0] expWord;
        int lvl, written, reads, cyc;
        logic doR, doW;
        for (int i = 0; i < 4; i++) stepA(1'b1, 8'hA0 + 8'(i), 1'b0);
        stepA(1'b1, 8'h55, 1'b1);
        checks++; if (aLevel !== 5'd1) begin errors++; $display("FAIL simul_level got %0d want 1", aLevel); end
        checks++; if (aDout !== 32'hA3A2A1A0 || aDv !== 1'b1) begin errors++; $display("FAIL simul_dout got %h valid=%b want a3a2a1a0 valid=1", aDout, aDv); end
        checks++; if (aOvf !== 1'b0 || aUnf !== 1'b0) begin errors++; $display("FAIL simul_errflags got %b%b want 00", aOvf, aUnf); end

        q.push_back(8'h55);
        lvl = 1; written = 0; reads = 0; cyc = 0;
        while ((written < 40 || reads < 10) && cyc < 200) begin
            doR = (lvl >= 4) && (reads < 10);
            doW = (written < 40) && (lvl <= 15);
            expWord = 32'h0;
            if (doR) expWord = {q[3], q[2], q[1], q[0]};
            stepA(doW, 8'h80 + 8'(written), doR);
            checks++;
            if (aDv !== doR) begin errors++; $display("FAIL stream_valid_c%0d got %b want %b", cyc, aDv, doR); end
            if (doR) begin
                checks++;
                if (aDout !== expWord) begin errors++; $display("FAIL stream_word_%0d got %h want %h", reads, aDout, expWord); end
                for (int k = 0; k < 4; k++) void'(q.pop_front());
                reads++;
                lvl -= 4;
            end
            if (doW) begin
                q.push_back(8'h80 + 8'(written));
                written++;
                lvl += 1;
            end
            cyc++;
        end
        checks++; if (cyc >= 200) begin errors++; $display("FAIL stream_timeout got %0d cycles want <200", cyc); end
        checks++; if (aLevel !== 5'd1) begin errors++; $display("FAIL stream_level got %0d want 1", aLevel); end
    endtask

    task automatic test_unpack();
        logic [7:0] expBytes [4];
        expBytes[0] = 8'hD4; expBytes[1] = 8'hC3; expBytes[2] = 8'hB2; expBytes[3] = 8'hA1;
        stepB(1'b1, 32'hA1B2C3D4, 1'b0);
        checks++; if (bLevel !== 5'd4 || bEmpty !== 1'b0 || bFull !== 1'b0) begin errors++; $display("FAIL unpack_wr got level=%0d empty=%b full=%b want 4/0/0", bLevel, bEmpty, bFull); end
        for (int i = 0; i < 4; i++) begin
            stepB(1'b0, 32'h0, 1'b1);
            checks++;
            if (bDout !== expBytes[i] || bDv !== 1'b1) begin errors++; $display("FAIL unpack_rd_%0d got %h valid=%b want %h valid=1", i, bDout, bDv, expBytes[i]); end
        end
        checks++; if (bUnf !== 1'b0 || bEmpty !== 1'b1) begin errors++; $display("FAIL unpack_pre got unf=%b empty=%b want 0/1", bUnf, bEmpty); end
        stepB(1'b0, 32'h0, 1'b1);
        checks++; if (bUnf !== 1'b1) begin errors++; $display("FAIL underflow_set got %b want 1", bUnf); end
        checks++; if (bDout !== 8'hA1 || bDv !== 1'b0) begin errors++; $display("FAIL underflow_dout got %h valid=%b want a1 valid=0", bDout, bDv); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 8; i++) stepA(1'b1, 8'h10 + 8'(i), 1'b0);
        stepA(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 4; i++) stepA(1'b1, 8'h20 + 8'(i), 1'b0);
        checks++; if (aLevel !== 5'd8 || aDout !== 32'h13121110) begin errors++; $display("FAIL midrst_setup got level=%0d dout=%h want 8/13121110", aLevel, aDout); end
        aWe = 1'b1; aRe = 1'b1; aDin = 8'h99;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (aLevel !== 5'd0 || aEmpty !== 1'b1 || aFull !== 1'b0 || aDout !== 32'h0 || aDv !== 1'b0 || aOvf !== 1'b0 || aUnf !== 1'b0) begin
            errors++; $display("FAIL midrst_async got level=%0d empty=%b dout=%h valid=%b want 0/1/0/0", aLevel, aEmpty, aDout, aDv);
        end
        @(posedge clk); #1;
        aWe = 1'b0; aRe = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) stepA(1'b1, 8'h01 + 8'(i), 1'b0);
        stepA(1'b0, 8'h00, 1'b1);
        checks++; if (aDout !== 32'h04030201 || aDv !== 1'b1) begin errors++; $display("FAIL midrst_fresh got %h valid=%b want 04030201 valid=1", aDout, aDv); end
        checks++; if (aLevel !== 5'd0) begin errors++; $display("FAIL midrst_level got %0d want 0", aLevel); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 16; i++) stepA(1'b1, 8'(i), 1'b0);
        stepA(1'b1, 8'hFF, 1'b0);
        stepA(1'b0, 8'h00, 1'b1);
        checks++; if (aLevel !== 5'd12 || aOvf !== 1'b1) begin errors++; $display("FAIL flush_setup got level=%0d ovf=%b want 12/1", aLevel, aOvf); end
        aFlush = 1'b1;
        stepA(1'b1, 8'hEE, 1'b0);
        aFlush = 1'b0;
        checks++; if (aLevel !== 5'd0 || aEmpty !== 1'b1) begin errors++; $display("FAIL flush_level got level=%0d empty=%b want 0/1", aLevel, aEmpty); end
        checks++; if (aOvf !== 1'b1) begin errors++; $display("FAIL flush_ovf got %b want 1", aOvf); end
        checks++; if (aDout !== 32'h03020100 || aDv !== 1'b0) begin errors++; $display("FAIL flush_dout got %h valid=%b want 03020100 valid=0", aDout, aDv); end
        aFlush = 1'b1;
        stepA(1'b0, 8'h00, 1'b1);
        aFlush = 1'b0;
        checks++; if (aUnf !== 1'b0) begin errors++; $display("FAIL flush_unf got %b want 0", aUnf); end
        for (int i = 0; i < 4; i++) stepA(1'b1, 8'hC1 + 8'(i), 1'b0);
        stepA(1'b0, 8'h00, 1'b1);
        checks++; if (aDout !== 32'hC4C3C2C1 || aDv !== 1'b1) begin errors++; $display("FAIL flush_fresh got %h valid=%b want c4c3c2c1 valid=1", aDout, aDv); end
        checks++; if (aLevel !== 5'd0) begin errors++; $display("FAIL flush_after_level got %0d want 0", aLevel); end
    endtask

    initial begin
        aWe = 0; aRe = 0; aFlush = 0; aDin = 0;
        bWe = 0; bRe = 0; bFlush = 0; bDin = 0;
        rst_n = 1'b1;
        #7;
        test_reset();
        test_basic_pack();
        test_full_overflow();
        applyReset();
        test_back_to_back();
        applyReset();
        test_unpack();
        applyReset();
        test_reset_mid();
        applyReset();
        test_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
